// File: rtl/deserializer_fc_if.sv
// Bus bundle for the fast-readout deserializer: serial link inputs and FIFO read side.
// The master modport is the deserializer; the slave modport is the link/consumer side.
interface deserializer_fc_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     serialIn;
    logic [1:0]               control;
    logic                     bitSlip;
    logic [15:0]              dataOut;
    logic                     dataValid;
    logic                     dataReady;
    logic                     receiving;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifoCount;

    modport master (
        input  serialIn, control, bitSlip, dataReady,
        output dataOut, dataValid, receiving, overflow, fifoCount
    );

    modport slave (
        output serialIn, control, bitSlip, dataReady,
        input  dataOut, dataValid, receiving, overflow, fifoCount
    );
endinterface

// File: rtl/deserializer_fc.sv
// Fast-readout link receiver: samples the serial stream MSB first into 16-bit words
// and queues them in a small FIFO with a valid/ready read port. Optional idle-word
// (16'hFFFF) suppression, bit-slip realignment and a sticky overflow flag.
module deserializer_fc #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          DROP_IDLE = 1'b1
) (
    input logic               FSclk,
    input logic               resetb,
    deserializer_fc_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {StIdle, StShift} state_t;

    state_t          state;
    logic [3:0]      bit_cnt;
    logic [14:0]     shift_reg;
    logic [15:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic            enabled;
    logic            word_done;
    logic            push_req;
    logic            full;
    logic            pop;
    logic            push;
    logic [15:0]     word;

    // Word completion and FIFO handshake decode
    always_comb begin
        enabled   = (bus.control == 2'b11);
        word      = {shift_reg, bus.serialIn};
        word_done = (state == StShift) && enabled && !bus.bitSlip && (bit_cnt == 4'd15);
        push_req  = word_done && !(DROP_IDLE && (word == 16'hFFFF));
        full      = (count == CW'(DEPTH));
        pop       = (count != '0) && bus.dataReady;
        // A full FIFO still takes the word when the head leaves on the same edge
        push      = push_req && (!full || pop);
    end

    // Receive FSM: E0 only arms the counter, sampling starts on the following edge
    always_ff @(posedge FSclk) begin
        if (!resetb) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (enabled) begin
                        state   <= StShift;
                        bit_cnt <= '0;
                    end
                end
                StShift: begin
                    if (!enabled) begin
                        state   <= StIdle;
                        bit_cnt <= '0;
                    end else if (!bus.bitSlip) begin
                        shift_reg <= word[14:0];
                        bit_cnt   <= bit_cnt + 4'd1;  // wraps to 0 on word complete
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge FSclk) begin
        if (resetb && push) begin
            mem[wr_ptr] <= word;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge FSclk) begin
        if (!resetb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    assign bus.dataOut   = (count != '0) ? mem[rd_ptr] : 16'h0000;
    assign bus.dataValid = (count != '0);
    assign bus.receiving = (state == StShift);
    assign bus.overflow  = overflow;
    assign bus.fifoCount = count;
endmodule

// File: tb/tb_deserializer_fc.sv
// Self-checking bench for deserializer_fc: a word table, directed corner sequences and
// a randomized run, all checked every cycle against a queue-based reference model.
module tb_deserializer_fc;
    localparam int unsigned DEPTH     = 4;
    localparam bit          DROP_IDLE = 1'b1;

    typedef struct {
        logic [15:0] word;
        logic        queued;
    } vec_t;

    logic clk;
    logic resetb;
    int   checks;
    int   failures;

    // Reference model state: link active flag, bits of the word in progress, FIFO
    bit          m_active;
    logic        m_bitq[$];
    logic [15:0] m_fifo[$];
    bit          m_ovf;

    deserializer_fc_if #(.DEPTH(DEPTH)) bus ();

    deserializer_fc #(
        .DEPTH    (DEPTH),
        .DROP_IDLE(DROP_IDLE)
    ) dut (
        .FSclk (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rb, input logic sin, input logic [1:0] ctl,
                              input logic slip, input logic rdy);
        logic [15:0] w;
        bit          have;
        bit          pop;
        int          sz;
        if (!rb) begin
            m_active = 0;
            m_bitq.delete();
            m_fifo.delete();
            m_ovf = 0;
            return;
        end
        sz   = m_fifo.size();
        pop  = (sz > 0) && rdy;
        have = 0;
        w    = '0;
        if (ctl != 2'b11) begin
            m_active = 0;
            m_bitq.delete();
        end else if (!m_active) begin
            m_active = 1;
            m_bitq.delete();
        end else if (!slip) begin
            m_bitq.push_back(sin);
            if (m_bitq.size() == 16) begin
                foreach (m_bitq[i]) w = {w[14:0], m_bitq[i]};
                have = 1;
                m_bitq.delete();
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (have && !(DROP_IDLE && w == 16'hFFFF)) begin
            if (sz == DEPTH && !pop) m_ovf = 1;
            else m_fifo.push_back(w);
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(bus.dataValid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) check("model_data", 32'(bus.dataOut), 32'(m_fifo[0]));
        check("model_receiving", 32'(bus.receiving), 32'(m_active));
        check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
        check("model_count", 32'(bus.fifoCount), 32'(m_fifo.size()));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge
    task automatic tick(input logic rb, input logic sin, input logic [1:0] ctl,
                        input logic slip, input logic rdy);
        resetb        = rb;
        bus.serialIn  = sin;
        bus.control   = ctl;
        bus.bitSlip   = slip;
        bus.dataReady = rdy;
        @(posedge clk);
        model_step(rb, sin, ctl, slip, rdy);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic start();
        tick(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [15:0] w, input logic rdy);
        for (int i = 15; i >= 0; i--) tick(1'b1, w[i], 2'b11, 1'b0, rdy);
    endtask

    initial begin
        vec_t        vecs [6];
        logic [15:0] ovw  [5];
        logic [16:0] s;
        int          rdy_pct;
        bit          ones_mode;

        checks   = 0;
        failures = 0;
        m_active = 0;
        m_ovf    = 0;

        vecs[0] = '{16'h1234, 1'b1};
        vecs[1] = '{16'hFFFF, 1'b0};
        vecs[2] = '{16'h8001, 1'b1};
        vecs[3] = '{16'h0000, 1'b1};
        vecs[4] = '{16'hFFFE, 1'b1};
        vecs[5] = '{16'hA5C3, 1'b1};
        ovw     = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

        // Reset state
        do_reset();
        check("rst_data", 32'(bus.dataOut), 32'h0);
        check("rst_valid", 32'(bus.dataValid), 32'h0);
        check("rst_receiving", 32'(bus.receiving), 32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        check("rst_count", 32'(bus.fifoCount), 32'h0);

        // Single word, receiving rises after E0
        start();
        check("e0_receiving", 32'(bus.receiving), 32'h1);
        send_word(16'hA5C3, 1'b0);
        check("single_data", 32'(bus.dataOut), 32'hA5C3);
        check("single_valid", 32'(bus.dataValid), 32'h1);
        check("single_count", 32'(bus.fifoCount), 32'h1);

        // Word table, streamed back to back with a consumer that always accepts
        do_reset();
        start();
        for (int k = 0; k < 6; k++) begin
            send_word(vecs[k].word, 1'b1);
            if (vecs[k].queued) begin
                check("table_valid", 32'(bus.dataValid), 32'h1);
                check("table_data", 32'(bus.dataOut), 32'(vecs[k].word));
            end else begin
                check("table_idle_dropped", 32'(bus.dataValid), 32'h0);
            end
        end
        check("table_overflow", 32'(bus.overflow), 32'h0);

        // Bit slip: extra leading 0 then 0x00FF, with and without a slip at E1
        s = {1'b0, 16'h00FF};
        for (int slip = 1; slip >= 0; slip--) begin
            do_reset();
            start();
            for (int i = 16; i >= 0; i--) tick(1'b1, s[i], 2'b11, (i == 16) && (slip == 1), 1'b0);
            check("slip_count", 32'(bus.fifoCount), 32'h1);
            check("slip_data", 32'(bus.dataOut), (slip == 1) ? 32'h00FF : 32'h007F);
        end

        // Overflow with a stalled consumer, then drain in order
        do_reset();
        start();
        for (int k = 0; k < 5; k++) send_word(ovw[k], 1'b0);
        check("ovf_count", 32'(bus.fifoCount), 32'h4);
        check("ovf_flag", 32'(bus.overflow), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("drain_data", 32'(bus.dataOut), 32'(ovw[k]));
            tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        end
        check("drain_empty", 32'(bus.dataValid), 32'h0);
        check("drain_ovf_sticky", 32'(bus.overflow), 32'h1);

        // Full FIFO: pop on the completing edge lets the word in
        do_reset();
        start();
        for (int k = 0; k < 4; k++) send_word(ovw[k], 1'b0);
        for (int i = 15; i >= 1; i--) tick(1'b1, ovw[4][i], 2'b11, 1'b0, 1'b0);
        tick(1'b1, ovw[4][0], 2'b11, 1'b0, 1'b1);
        check("fullpop_overflow", 32'(bus.overflow), 32'h0);
        check("fullpop_count", 32'(bus.fifoCount), 32'h4);
        check("fullpop_head", 32'(bus.dataOut), 32'(ovw[1]));

        // Control drops after 7 bits; partial word is discarded
        do_reset();
        start();
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        check("disabled_receiving", 32'(bus.receiving), 32'h0);
        start();
        send_word(16'hBEEF, 1'b0);
        check("reenable_count", 32'(bus.fifoCount), 32'h1);
        check("reenable_data", 32'(bus.dataOut), 32'hBEEF);

        // Reset mid-word with two words queued, then a clean realignment
        send_word(16'h1357, 1'b0);
        check("pre_rst_count", 32'(bus.fifoCount), 32'h2);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        check("midrst_data", 32'(bus.dataOut), 32'h0);
        check("midrst_valid", 32'(bus.dataValid), 32'h0);
        check("midrst_receiving", 32'(bus.receiving), 32'h0);
        check("midrst_count", 32'(bus.fifoCount), 32'h0);
        start();
        send_word(16'h2468, 1'b0);
        check("postrst_data", 32'(bus.dataOut), 32'h2468);
        check("postrst_count", 32'(bus.fifoCount), 32'h1);

        // Randomized run against the model
        do_reset();
        rdy_pct   = 50;
        ones_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rdy_pct = (c / 500 % 3 == 0) ? 5 : ((c / 500 % 3 == 1) ? 50 : 95);
            if (c % 150 == 0) ones_mode = ($urandom_range(0, 3) == 0);
            tick(($urandom_range(0, 299) != 0),
                 ones_mode ? 1'b1 : 1'($urandom),
                 ($urandom_range(0, 39) == 0) ? 2'($urandom) : 2'b11,
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 99) < rdy_pct));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
